cabac_bae_low_engine: RTL

CABAC_BAE_LOW_ENGINE -- requirements
Module: cabac_bae_low_engine

---
 rtl/cabac_bae_low_engine_pkg.sv | 21 ++
 rtl/cabac_bae_low_engine_byp_mult.sv | 31 +++
 rtl/cabac_bae_low_engine.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cabac_bae_low_engine_pkg.sv
// Shared CABAC binary-arithmetic-encoder definitions: beat mode encodings
// and common field widths used by the low-register engine.
package cabac_bae_low_engine_pkg;

  // Beat mode carried on mode_i.
  typedef enum logic [1:0] {
    MODE_REGULAR  = 2'b00,
    MODE_NULL     = 2'b01,
    MODE_BYPASS   = 2'b10,
    MODE_TERMINAL = 2'b11
  } bae_mode_e;

  // Width of renorm shift, bypass count and emitted-bit count fields.
  localparam int unsigned NUM_W = 4;

  // A beat produces an output beat unless it is a null beat.
  function automatic logic mode_produces(input bae_mode_e mode);
    return (mode != MODE_NULL);
  endfunction

endpackage

// File: rtl/cabac_bae_low_engine_byp_mult.sv
// Combinational shift-add product of the current range and the bypass bin
// vector. Each set bin contributes range weighted by its bit position.
module cabac_bae_byp_mult #(
  parameter int RANGE_W = 9,
  parameter int MAX_BYP = 5
) (
  input  logic [RANGE_W-1:0]         range_i,
  input  logic [MAX_BYP-1:0]         bins_i,
  output logic [RANGE_W+MAX_BYP-1:0] prod_o
);

  logic [RANGE_W+MAX_BYP-1:0] range_ext_s;
  logic [RANGE_W+MAX_BYP-1:0] acc_s;

  assign range_ext_s = {{MAX_BYP{1'b0}}, range_i};

  // Accumulate the shifted range for every set bin position.
  always_comb begin
    acc_s = '0;
    for (int i = 0; i < MAX_BYP; i++) begin
      if (bins_i[i]) begin
        acc_s = acc_s + (range_ext_s << i);
      end else begin
        acc_s = acc_s;
      end
    end
  end

  assign prod_o = acc_s;

endmodule

// File: rtl/cabac_bae_low_engine.sv
// CABAC binary arithmetic encoder low-register engine. Accepts one coding
// beat per cycle, updates low and emits the overflow bits and carry of that
// beat through a single registered output stage with valid/ready handshake.
module cabac_bae_low_engine
  import cabac_bae_low_engine_pkg::*;
#(
  parameter int LOW_W   = 10,
  parameter int RANGE_W = 9,
  parameter int MAX_BYP = 5,
  parameter int OVF_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_i,
  input  logic [LOW_W-1:0]   init_low_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [1:0]         mode_i,
  input  logic               bin_eq_lps_i,
  input  logic               bin_neq_mps_i,
  input  logic [3:0]         shift_i,
  input  logic [RANGE_W-1:0] t_range_i,
  input  logic [RANGE_W-1:0] range_i,
  input  logic [3:0]         byp_num_i,
  input  logic [MAX_BYP-1:0] byp_bins_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [3:0]         ovf_num_o,
  output logic [OVF_W-1:0]   ovf_bits_o,
  output logic               carry_o,
  output logic [LOW_W-1:0]   low_o
);

  // Full-width working vector: wide enough for low shifted by the largest
  // renorm/bypass count plus the bypass product, so nothing truncates
  // before the emitted bits are extracted.
  localparam int FW = LOW_W + RANGE_W + OVF_W + 2;
  localparam int PW = RANGE_W + MAX_BYP;

  bae_mode_e          mode_s;
  logic               accept_s;
  logic               produce_s;
  logic [LOW_W-1:0]   base_low_s;
  logic [FW-1:0]      base_ext_s;
  logic [FW-1:0]      t_ext_s;
  logic [FW-1:0]      sum_s;
  logic [FW-1:0]      prod_ext_s;
  logic [FW-1:0]      one_s;
  logic [FW-1:0]      f_s;
  logic [PW-1:0]      prod_s;
  logic [NUM_W-1:0]   num_s;
  logic               carry_s;
  logic [OVF_W-1:0]   hi_s;
  logic [OVF_W-1:0]   bits_s;
  logic [LOW_W-1:0]   new_low_s;
  logic               unused_s;

  logic [LOW_W-1:0]   low_r;
  logic               valid_r;
  logic [NUM_W-1:0]   ovf_num_r;
  logic [OVF_W-1:0]   ovf_bits_r;
  logic               carry_r;

  assign mode_s    = bae_mode_e'(mode_i);
  assign ready_o   = !valid_r | ready_i;
  assign accept_s  = valid_i & ready_o;
  assign produce_s = accept_s & mode_produces(mode_s);

  // An init in the same cycle as a beat makes the beat start from init_low_i.
  assign base_low_s = init_i ? init_low_i : low_r;
  assign base_ext_s = {{(FW-LOW_W){1'b0}}, base_low_s};
  assign t_ext_s    = {{(FW-RANGE_W){1'b0}}, t_range_i};
  assign prod_ext_s = {{(FW-PW){1'b0}}, prod_s};
  assign sum_s      = base_ext_s + t_ext_s;
  assign one_s      = {{(FW-1){1'b0}}, 1'b1};

  cabac_bae_byp_mult #(
    .RANGE_W (RANGE_W),
    .MAX_BYP (MAX_BYP)
  ) u_byp_mult (
    .range_i (range_i),
    .bins_i  (byp_bins_i),
    .prod_o  (prod_s)
  );

  // Compute the full-width F, emitted-bit count and carry for the beat mode.
  always_comb begin
    f_s     = base_ext_s;
    num_s   = 4'd0;
    carry_s = 1'b0;
    case (mode_s)
      MODE_REGULAR: begin
        if (bin_eq_lps_i) begin
          f_s     = {{(FW-LOW_W){1'b0}}, sum_s[LOW_W-1:0]} << shift_i;
          num_s   = shift_i;
          carry_s = sum_s[LOW_W];
        end else if (bin_neq_mps_i) begin
          f_s   = base_ext_s;
          num_s = 4'd0;
        end else begin
          f_s   = base_ext_s << 4'd1;
          num_s = 4'd1;
        end
      end
      MODE_TERMINAL: begin
        if (bin_eq_lps_i) begin
          f_s     = sum_s;
          num_s   = 4'd0;
          carry_s = sum_s[LOW_W];
        end else if (t_range_i[RANGE_W-1]) begin
          f_s   = base_ext_s;
          num_s = 4'd0;
        end else begin
          f_s   = base_ext_s << 4'd1;
          num_s = 4'd1;
        end
      end
      MODE_BYPASS: begin
        f_s     = (base_ext_s << byp_num_i) + prod_ext_s;
        num_s   = byp_num_i;
        carry_s = |(f_s & ((one_s << LOW_W) << byp_num_i));
      end
      MODE_NULL: begin
        f_s     = base_ext_s;
        num_s   = 4'd0;
        carry_s = 1'b0;
      end
      default: begin
        f_s     = base_ext_s;
        num_s   = 4'd0;
        carry_s = 1'b0;
      end
    endcase
  end

  assign hi_s      = f_s[LOW_W +: OVF_W];
  assign new_low_s = f_s[LOW_W-1:0];
  assign unused_s  = ^f_s[FW-1:LOW_W+OVF_W];

  // Keep only the low num_s bits of the overflow field; upper bits read zero.
  always_comb begin
    bits_s = '0;
    for (int i = 0; i < OVF_W; i++) begin
      if (i < int'(num_s)) begin
        bits_s[i] = hi_s[i];
      end else begin
        bits_s[i] = 1'b0;
      end
    end
  end

  // Low register: updated by a producing beat, otherwise by a bare init.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_r <= '0;
    end else if (produce_s) begin
      low_r <= new_low_s;
    end else if (init_i) begin
      low_r <= init_low_i;
    end else begin
      low_r <= low_r;
    end
  end

  // Output stage: load on a producing beat, drop after downstream accept,
  // otherwise hold every field stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r    <= 1'b0;
      ovf_num_r  <= '0;
      ovf_bits_r <= '0;
      carry_r    <= 1'b0;
    end else if (produce_s) begin
      valid_r    <= 1'b1;
      ovf_num_r  <= num_s;
      ovf_bits_r <= bits_s;
      carry_r    <= carry_s;
    end else if (ready_i) begin
      valid_r    <= 1'b0;
      ovf_num_r  <= ovf_num_r;
      ovf_bits_r <= ovf_bits_r;
      carry_r    <= carry_r;
    end else begin
      valid_r    <= valid_r;
      ovf_num_r  <= ovf_num_r;
      ovf_bits_r <= ovf_bits_r;
      carry_r    <= carry_r;
    end
  end

  assign valid_o    = valid_r;
  assign ovf_num_o  = ovf_num_r;
  assign ovf_bits_o = ovf_bits_r;
  assign carry_o    = carry_r;
  assign low_o      = low_r;

endmodule
